// File: rtl/sixty_four_bit_add_sub_div.sv
// Registered 64-bit add/sub/pass unit with a 32-bit unsigned restoring divider.
// Optional feature macro REMAINDER_EN adds a remainder[31:0] output port.
module sixty_four_bit_add_sub_div #(
  parameter int DIV_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [63:0]       a_in,
  input  logic [63:0]       b_in,
  input  logic              c_in,
  output logic [63:0]       result,
  output logic              carry_out,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
`ifdef REMAINDER_EN
  output logic [DIV_W-1:0]  remainder,
`endif
  output logic [1:0]        fsm_state
);

  // Handshake: start is a request that is accepted only in a cycle where
  // busy=0; done is a single-cycle valid pulse qualifying result and flags.

  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_W - 1);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_DZERO = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] quot_q;
  logic [DIV_W-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;

  logic [64:0]      sum65;
  logic [64:0]      diff65;
  logic [DIV_W:0]   rem_sh;
  logic             rem_ge;
  logic [DIV_W-1:0] rem_nx;
  logic [DIV_W-1:0] quot_nx;
  logic             accept;
  logic             last_iter;

  assign accept    = start && (state == S_IDLE);
  assign last_iter = (state == S_DIV) && (cnt_q == LAST_CNT);
  assign busy      = (state != S_IDLE);
  assign zero      = (result == 64'd0);
  assign fsm_state = state;

  // Arithmetic and one restoring-division step, all combinational.
  always_comb begin
    sum65   = {1'b0, a_in} + {1'b0, b_in} + 65'(c_in);
    diff65  = {1'b0, a_in} + {1'b0, ~b_in} + 65'd1;
    rem_sh  = {rem_q, quot_q[DIV_W-1]};
    rem_ge  = (rem_sh >= {1'b0, divisor_q});
    rem_nx  = rem_ge ? DIV_W'(rem_sh - {1'b0, divisor_q}) : rem_sh[DIV_W-1:0];
    quot_nx = {quot_q[DIV_W-2:0], rem_ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start && (op == OP_DIV)) begin
          state_nx = (b_in[DIV_W-1:0] == '0) ? S_DZERO : S_DIV;
        end
      end
      S_DIV: begin
        if (cnt_q == LAST_CNT) state_nx = S_IDLE;
      end
      S_DZERO: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result      <= 64'd0;
      carry_out   <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      rem_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            case (op)
              OP_ADD: begin
                result    <= sum65[63:0];
                carry_out <= sum65[64];
                done      <= 1'b1;
              end
              OP_SUB: begin
                result    <= diff65[63:0];
                carry_out <= diff65[64];
                done      <= 1'b1;
              end
              OP_PASS: begin
                result    <= a_in;
                carry_out <= 1'b0;
                done      <= 1'b1;
              end
              default: begin
                // Divide: result and carry hold until the divide completes.
                rem_q     <= '0;
                quot_q    <= a_in[DIV_W-1:0];
                divisor_q <= b_in[DIV_W-1:0];
                cnt_q     <= '0;
              end
            endcase
          end
        end
        S_DIV: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            result    <= 64'(quot_nx);
            carry_out <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_DZERO: begin
          result      <= 64'({DIV_W{1'b1}});
          carry_out   <= 1'b0;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef REMAINDER_EN
  // quot_q still holds the untouched dividend while in S_DZERO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remainder <= '0;
    end else if (accept && (op != OP_DIV)) begin
      remainder <= '0;
    end else if (last_iter) begin
      remainder <= rem_nx;
    end else if (state == S_DZERO) begin
      remainder <= quot_q;
    end
  end
`endif

endmodule

// File: tb/tb_sixty_four_bit_add_sub_div.sv
// Directed plus randomized checks of sixty_four_bit_add_sub_div against an arithmetic model.
module tb_sixty_four_bit_add_sub_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        c_in;
  logic [63:0] result;
  logic        carry_out;
  logic        zero;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [1:0]  fsm_state;
`ifdef REMAINDER_EN
  logic [31:0] remainder;
`endif

  sixty_four_bit_add_sub_div dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .c_in        (c_in),
    .result      (result),
    .carry_out   (carry_out),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
`ifdef REMAINDER_EN
    .remainder   (remainder),
`endif
    .fsm_state   (fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard entry: {remainder[31:0], div_by_zero, carry, result[63:0]}
  logic [97:0] exp_q[$];
  logic [63:0] last_res;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic logic [97:0] model(input logic [1:0] o, input logic [63:0] a,
                                        input logic [63:0] b, input logic ci);
    logic [64:0] s;
    logic [31:0] dd, dv;
    model = '0;
    case (o)
      2'b00: begin
        s = 65'(a) + 65'(b) + 65'(ci);
        model = {32'd0, 1'b0, s[64], s[63:0]};
      end
      2'b01: model = {32'd0, 1'b0, (a >= b), a - b};
      2'b11: model = {32'd0, 1'b0, 1'b0, a};
      default: begin
        dd = a[31:0];
        dv = b[31:0];
        if (dv == 32'd0) model = {dd, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF};
        else             model = {dd % dv, 1'b0, 1'b0, 64'(dd / dv)};
      end
    endcase
  endfunction

  task automatic scramble_inputs();
    a_in = {$urandom, $urandom};
    b_in = {$urandom, $urandom};
    c_in = 1'($urandom);
    op   = 2'($urandom);
  endtask

  task automatic check_outputs(input string tag, input logic [97:0] e);
    check({tag, " result"}, result, e[63:0]);
    check({tag, " carry"}, 64'(carry_out), 64'(e[64]));
    check({tag, " zero"}, 64'(zero), 64'(e[63:0] == 64'd0));
    check({tag, " dbz"}, 64'(div_by_zero), 64'(e[65]));
`ifdef REMAINDER_EN
    check({tag, " remainder"}, 64'(remainder), 64'(e[97:66]));
`endif
  endtask

  // driver task: one operation, inputs scrambled after the start edge
  task automatic do_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input string tag);
    int lat;
    int exp_lat;
    logic [97:0] e;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b; c_in = ci;
    exp_q.push_back(model(o, a, b, ci));
    exp_lat = (o == 2'b10) ? ((b[31:0] == 32'd0) ? 2 : 33) : 1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    lat = 1;
    if (o == 2'b10) check({tag, " busy"}, 64'(busy), 64'd1);
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    check_outputs(tag, e);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    last_res = e[63:0];
  endtask

  initial begin
    int lat;
    bit saw_done;
    logic [1:0] ro;
    logic [63:0] ra, rb;

    reset = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset result", result, 64'd0);
    check("reset zero", 64'(zero), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset carry", 64'(carry_out), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    do_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_wrap");
    do_op(2'b01, 64'd5, 64'd7, 1'b1, "sub_neg");
    do_op(2'b01, 64'd7, 64'd5, 1'b0, "sub_pos");
    do_op(2'b11, 64'hDEAD_BEEF_0123_4567, 64'd9, 1'b1, "pass");
    do_op(2'b10, 64'd100, 64'd7, 1'b0, "div_100_7");
    repeat (3) @(negedge clk);
    check("hold result", result, last_res);
    check("done pulse one cycle", 64'(done), 64'd0);
    do_op(2'b10, 64'd9, 64'd0, 1'b0, "div_zero");
    do_op(2'b00, 64'd1, 64'd2, 1'b1, "add_after_dz");
    do_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0001, 1'b0, "div_max_1");

    // back-to-back add then sub
    @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 64'd10; b_in = 64'd20; c_in = 1'b1;
    @(negedge clk);
    check("b2b first done", 64'(done), 64'd1);
    check("b2b first result", result, 64'd31);
    op = 2'b01; a_in = 64'd3; b_in = 64'd3;
    @(negedge clk);
    check("b2b second done", 64'(done), 64'd1);
    check("b2b second result", result, 64'd0);
    check("b2b second carry", 64'(carry_out), 64'd1);
    check("b2b second zero", 64'(zero), 64'd1);
    start = 1'b0;
    @(negedge clk);
    check("b2b done cleared", 64'(done), 64'd0);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b10; a_in = 64'd1000; b_in = 64'd33; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 64'd5; b_in = 64'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start done seen", 64'(lat < 60), 64'd1);
    check_outputs("busy_start", model(2'b10, 64'd1000, 64'd33, 1'b0));
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("busy_start no extra done", 64'(saw_done), 64'd0);

    // randomized operations
    for (int i = 0; i < 25; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (ro == 2'b10 && $urandom_range(0, 3) == 0) rb[31:0] = 32'($urandom_range(0, 20));
      do_op(ro, ra, rb, 1'($urandom), $sformatf("rand%0d", i));
    end

    // reset in the middle of a divide
    do_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "pre_reset");
    @(negedge clk);
    start = 1'b1; op = 2'b10; a_in = 64'd100; b_in = 64'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset result", result, 64'd0);
    check("midreset zero", 64'(zero), 64'd1);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset carry", 64'(carry_out), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midreset no done", 64'(saw_done), 64'd0);
    do_op(2'b00, 64'd40, 64'd2, 1'b0, "after_reset");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
